seg_channel_scanner: RTL and testbench

// - Parametrised successor of the board-level switch mux / 7-segment decoder.
// - Selects one of NCH input channels (WIDTH bits each), either manually or by timed auto-scan.
// - Drives the selected channel's data on LEDs and shows the channel index as a hex digit on SEG.
// - Sits between the SWI inputs and the LED/SEG outputs in top; clocked by clk_2.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_channel_scanner.sv | 140 ++++++++++++++
 tb/tb_seg_channel_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the channel scanner: FSM states and the 7-segment glyph table.
package seg_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high, glyphs 0..F
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to 7-segment glyph lookup; zero latency, no flow control.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg7
);

    assign o_seg7 = HEX7[i_nib];

endmodule

// File: rtl/seg_channel_scanner.sv
// Selects one of NCH channels (manual or timed auto-scan) and drives its data plus a hex index digit.
// All outputs registered: one clk_2 edge from input change to output; no backpressure.
module seg_channel_scanner
    import seg_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int WIDTH    = 2,
    parameter int SCAN_DIV = 4,
    localparam int CW      = $clog2(NCH)
) (
    input  logic                 i_clk_2,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_hold,
    input  logic [CW-1:0]        i_sel,
    input  logic [NCH*WIDTH-1:0] i_ch_data,
    output logic [WIDTH-1:0]     o_led_out,
    output logic [7:0]           o_seg,
    output logic [CW-1:0]        o_cur_ch,
    output logic                 o_step
);

    localparam int              CNTW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CH_MAX  = CW'(NCH - 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(SCAN_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_ch;
    logic [CW-1:0]    w_ch_nxt;
    logic [CW-1:0]    w_sel_clamp;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic             r_step;
    logic             w_step_nxt;
    logic [WIDTH-1:0] r_led;
    logic [WIDTH-1:0] w_led_nxt;
    logic [WIDTH-1:0] w_led_live;
    logic [7:0]       r_seg;
    logic [7:0]       w_seg_nxt;
    logic [3:0]       w_nib;
    logic [6:0]       w_hex;

    // Non-power-of-two NCH leaves sel codes with no channel behind them
    assign w_sel_clamp = (int'(i_sel) >= NCH) ? CH_MAX : i_sel;
    assign w_led_live  = i_ch_data[int'(w_ch_nxt) * WIDTH +: WIDTH];
    assign w_nib       = 4'(w_ch_nxt);

    seg_hex_decoder u_hex (
        .i_nib  (w_nib),
        .o_seg7 (w_hex)
    );

    always_ff @(posedge i_clk_2) begin
        if (i_reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!i_en) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF, S_HOLD: begin
                    if (!i_hold) w_next = i_mode ? S_SCAN : S_MANUAL;
                end
                default: begin
                    if (i_hold) w_next = S_HOLD;
                    else        w_next = i_mode ? S_SCAN : S_MANUAL;
                end
            endcase
        end
    end

    // Channel/counter actions follow the state being entered, so changes land on this edge
    always_comb begin
        w_ch_nxt   = r_ch;
        w_cnt_nxt  = r_cnt;
        w_step_nxt = 1'b0;
        case (w_next)
            S_MANUAL: begin
                w_ch_nxt  = w_sel_clamp;
                w_cnt_nxt = '0;
            end
            S_SCAN: begin
                if (r_state != S_SCAN) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt  = '0;
                    w_ch_nxt   = (r_ch == CH_MAX) ? '0 : r_ch + 1'b1;
                    w_step_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_led_nxt = r_led;
        w_seg_nxt = SEG_OFF;
        case (w_next)
            S_OFF:              w_led_nxt = '0;
            S_MANUAL, S_SCAN: begin
                w_led_nxt = w_led_live;
                w_seg_nxt = {1'b0, w_hex};
            end
            S_HOLD:             w_seg_nxt = {1'b1, w_hex};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_2) begin
        if (i_reset) begin
            r_ch   <= '0;
            r_cnt  <= '0;
            r_step <= 1'b0;
            r_led  <= '0;
            r_seg  <= SEG_OFF;
        end else begin
            r_ch   <= w_ch_nxt;
            r_cnt  <= w_cnt_nxt;
            r_step <= w_step_nxt;
            r_led  <= w_led_nxt;
            r_seg  <= w_seg_nxt;
        end
    end

    assign o_led_out = r_led;
    assign o_seg     = r_seg;
    assign o_cur_ch  = r_ch;
    assign o_step    = r_step;

endmodule

// File: tb/tb_seg_channel_scanner.sv
// Directed bench for seg_channel_scanner: main config NCH=4, plus NCH=3 clamp/wrap and NCH=16 wrap.
module tb_seg_channel_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic mode  = 1'b0;
    logic hold  = 1'b0;

    // NCH=4, WIDTH=2, SCAN_DIV=4
    logic       en0   = 1'b0;
    logic [1:0] sel0  = '0;
    logic [7:0] data0 = '0;
    logic [1:0] led0;
    logic [7:0] seg0;
    logic [1:0] cur0;
    logic       step0;

    // NCH=3, WIDTH=2, SCAN_DIV=2
    logic       en3   = 1'b0;
    logic [1:0] sel3  = '0;
    logic [5:0] data3 = '0;
    logic [1:0] led3;
    logic [7:0] seg3;
    logic [1:0] cur3;
    logic       step3;

    // NCH=16, WIDTH=2, SCAN_DIV=1
    logic        en16   = 1'b0;
    logic [3:0]  sel16  = '0;
    logic [31:0] data16 = '0;
    logic [1:0]  led16;
    logic [7:0]  seg16;
    logic [3:0]  cur16;
    logic        step16;

    seg_channel_scanner #(.NCH(4), .WIDTH(2), .SCAN_DIV(4)) u_dut0 (
        .i_clk_2(clk), .i_reset(reset), .i_en(en0), .i_mode(mode), .i_hold(hold),
        .i_sel(sel0), .i_ch_data(data0),
        .o_led_out(led0), .o_seg(seg0), .o_cur_ch(cur0), .o_step(step0)
    );

    seg_channel_scanner #(.NCH(3), .WIDTH(2), .SCAN_DIV(2)) u_dut3 (
        .i_clk_2(clk), .i_reset(reset), .i_en(en3), .i_mode(mode), .i_hold(hold),
        .i_sel(sel3), .i_ch_data(data3),
        .o_led_out(led3), .o_seg(seg3), .o_cur_ch(cur3), .o_step(step3)
    );

    seg_channel_scanner #(.NCH(16), .WIDTH(2), .SCAN_DIV(1)) u_dut16 (
        .i_clk_2(clk), .i_reset(reset), .i_en(en16), .i_mode(mode), .i_hold(hold),
        .i_sel(sel16), .i_ch_data(data16),
        .o_led_out(led16), .o_seg(seg16), .o_cur_ch(cur16), .o_step(step16)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [1:0] led, input logic [7:0] seg,
                        input logic [1:0] cur, input logic step);
        chk({tag, ".led"},  32'(led0),  32'(led));
        chk({tag, ".seg"},  32'(seg0),  32'(seg));
        chk({tag, ".cur"},  32'(cur0),  32'(cur));
        chk({tag, ".step"}, 32'(step0), 32'(step));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk0("reset_off", 2'b00, 8'h00, 2'd0, 1'b0);

        en0 = 1'b1; data0 = 8'b11_10_01_00; sel0 = 2'd2;
        tick();
        chk0("manual_sel2", 2'b10, 8'h5B, 2'd2, 1'b0);

        sel0 = 2'd1;
        tick();
        chk0("manual_sel1", 2'b01, 8'h06, 2'd1, 1'b0);

        sel0 = 2'd2;
        tick();
        mode = 1'b1;
        tick();
        chk0("scan_enter", 2'b10, 8'h5B, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk0("scan_wait2", 2'b10, 8'h5B, 2'd2, 1'b0);
        end
        tick();
        chk0("scan_adv3", 2'b11, 8'h4F, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk0("scan_wait3", 2'b11, 8'h4F, 2'd3, 1'b0);
        end
        tick();
        chk0("scan_wrap0", 2'b00, 8'h3F, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk0("scan_adv1", 2'b01, 8'h06, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Next edge would advance; hold must win
        hold = 1'b1;
        tick();
        chk0("hold_vs_adv", 2'b01, 8'h86, 2'd1, 1'b0);
        data0 = 8'b01_00_11_10;
        tick();
        tick();
        chk0("hold_frozen", 2'b01, 8'h86, 2'd1, 1'b0);

        hold = 1'b0;
        tick();
        chk0("release", 2'b11, 8'h06, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk0("release_wait", 2'b11, 8'h06, 2'd1, 1'b0);
        end
        tick();
        chk0("release_adv", 2'b00, 8'h5B, 2'd2, 1'b1);

        en0 = 1'b0; hold = 1'b1;
        tick();
        chk0("en0_hold1", 2'b00, 8'h00, 2'd2, 1'b0);

        en0 = 1'b1; hold = 1'b0;
        tick();
        chk0("off_to_scan", 2'b00, 8'h5B, 2'd2, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk0("reset_midscan", 2'b00, 8'h00, 2'd0, 1'b0);
        reset = 1'b0; en0 = 1'b0; mode = 1'b0;
        tick();

        en3 = 1'b1; sel3 = 2'd3; data3 = 6'b10_01_00;
        tick();
        chk("n3_clamp.cur", 32'(cur3), 32'd2);
        chk("n3_clamp.led", 32'(led3), 32'b10);
        chk("n3_clamp.seg", 32'(seg3), 32'h5B);
        mode = 1'b1;
        tick();
        tick();
        chk("n3_wait.step", 32'(step3), 32'd0);
        chk("n3_wait.cur",  32'(cur3),  32'd2);
        tick();
        chk("n3_wrap.cur",  32'(cur3),  32'd0);
        chk("n3_wrap.seg",  32'(seg3),  32'h3F);
        chk("n3_wrap.step", 32'(step3), 32'd1);
        en3 = 1'b0; mode = 1'b0;
        tick();

        en16 = 1'b1; sel16 = 4'hF; data16 = 32'hC000_0001;
        tick();
        chk("n16_man.cur", 32'(cur16), 32'hF);
        chk("n16_man.seg", 32'(seg16), 32'h71);
        chk("n16_man.led", 32'(led16), 32'b11);
        mode = 1'b1;
        tick();
        chk("n16_enter.cur",  32'(cur16),  32'hF);
        chk("n16_enter.step", 32'(step16), 32'd0);
        tick();
        chk("n16_wrap.cur",  32'(cur16),  32'h0);
        chk("n16_wrap.seg",  32'(seg16),  32'h3F);
        chk("n16_wrap.led",  32'(led16),  32'b01);
        chk("n16_wrap.step", 32'(step16), 32'd1);
        tick();
        chk("n16_next.cur",  32'(cur16),  32'h1);
        chk("n16_next.seg",  32'(seg16),  32'h06);
        chk("n16_next.step", 32'(step16), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
